// File: rtl/fp_add_control.sv
// Sequencer for the FP add/subtract datapath: drives selects, shift amounts and load from flops.
// Optional macro FP_CTRL_ROUND_RETRY_EN enables repeated final passes on rounding overflow.
module fp_add_control #(
    parameter int MAX_RETRY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sign_1,
    input  logic        sign_2,
    input  logic [7:0]  saida_registrador,
    input  logic [7:0]  tamanhoShift,
    input  logic        directionShift,
    input  logic        overflow,
    input  logic [31:0] saida_final,
    output logic        soma_multiplica_small_ula,
    output logic        soma_multiplica_big_ula,
    output logic        subtrador_big_ula,
    output logic [4:0]  tamanho,
    output logic [4:0]  tamanho2,
    output logic [7:0]  tamanho3,
    output logic        decisor_mux_expoente_escolhido,
    output logic        decisor_mux_saida_big_ula,
    output logic        decisor_shift_right_left,
    output logic        subtrador_Somador_subtrador,
    output logic        load,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_EXP,
        S_EXP_SET,
        S_EXP_LOAD,
        S_NORM_SET,
        S_NORM_LOAD,
        S_FIN_SET,
        S_FIN_LOAD,
        S_CHECK,
        S_DONE
    } state_t;

    state_t r_state;

    if (MAX_RETRY < 0 || MAX_RETRY > 3) begin : g_bad_retry
        $error("fp_add_control: MAX_RETRY must be in 0..3");
    end

    logic [4:0] w_align_amt;
    logic [7:0] w_norm_exp;
    logic [4:0] w_norm_shift;

    assign w_align_amt  = (saida_registrador > 8'd31) ? 5'd31 : saida_registrador[4:0];
    assign w_norm_exp   = tamanhoShift - {7'd0, directionShift};
    assign w_norm_shift = tamanhoShift[4:0] - {4'd0, directionShift};

`ifdef FP_CTRL_ROUND_RETRY_EN
    localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);
    logic [1:0] r_retry;
`else
    logic w_unused_overflow;
    assign w_unused_overflow = overflow;
`endif

    // Alignment shift and exponent-select setup share one cycle, so DONE lands nine cycles after start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state                        <= S_IDLE;
            soma_multiplica_small_ula      <= 1'b1;
            soma_multiplica_big_ula        <= 1'b1;
            subtrador_big_ula              <= 1'b0;
            tamanho                        <= 5'd0;
            tamanho2                       <= 5'd0;
            tamanho3                       <= 8'd0;
            decisor_mux_expoente_escolhido <= 1'b0;
            decisor_mux_saida_big_ula      <= 1'b0;
            decisor_shift_right_left       <= 1'b0;
            subtrador_Somador_subtrador    <= 1'b0;
            load                           <= 1'b0;
            busy                           <= 1'b0;
            done                           <= 1'b0;
            result                         <= 32'd0;
`ifdef FP_CTRL_ROUND_RETRY_EN
            r_retry                        <= 2'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    load <= 1'b0;
                    done <= 1'b0;
`ifdef FP_CTRL_ROUND_RETRY_EN
                    r_retry <= 2'd0;
`endif
                    if (start) begin
                        r_state           <= S_EXP;
                        busy              <= 1'b1;
                        subtrador_big_ula <= sign_1 ^ sign_2;
                    end
                end
                S_EXP: begin
                    tamanho                        <= w_align_amt;
                    tamanho3                       <= saida_registrador;
                    decisor_mux_expoente_escolhido <= 1'b0;
                    subtrador_Somador_subtrador    <= 1'b0;
                    r_state                        <= S_EXP_SET;
                end
                S_EXP_SET: begin
                    load    <= 1'b1;
                    r_state <= S_EXP_LOAD;
                end
                S_EXP_LOAD: begin
                    load                           <= 1'b0;
                    tamanho3                       <= w_norm_exp;
                    tamanho2                       <= w_norm_shift;
                    decisor_shift_right_left       <= directionShift;
                    decisor_mux_expoente_escolhido <= 1'b1;
                    subtrador_Somador_subtrador    <= 1'b1;
                    decisor_mux_saida_big_ula      <= 1'b0;
                    r_state                        <= S_NORM_SET;
                end
                S_NORM_SET: begin
                    load    <= 1'b1;
                    r_state <= S_NORM_LOAD;
                end
                S_NORM_LOAD: begin
                    load                           <= 1'b0;
                    tamanho3                       <= 8'd1;
                    tamanho2                       <= 5'd1;
                    decisor_shift_right_left       <= 1'b0;
                    subtrador_Somador_subtrador    <= 1'b0;
                    decisor_mux_expoente_escolhido <= 1'b1;
                    decisor_mux_saida_big_ula      <= 1'b0;
                    r_state                        <= S_FIN_SET;
                end
                S_FIN_SET: begin
                    load    <= 1'b1;
                    r_state <= S_FIN_LOAD;
                end
                S_FIN_LOAD: begin
                    load    <= 1'b0;
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
`ifdef FP_CTRL_ROUND_RETRY_EN
                    if (overflow && (r_retry < RETRY_LIM)) begin
                        r_retry                   <= r_retry + 2'd1;
                        decisor_mux_saida_big_ula <= 1'b1;
                        r_state                   <= S_FIN_SET;
                    end else begin
                        done    <= 1'b1;
                        result  <= saida_final;
                        r_state <= S_DONE;
                    end
`else
                    done    <= 1'b1;
                    result  <= saida_final;
                    r_state <= S_DONE;
`endif
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    load    <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_control.sv
// Scoreboard bench for fp_add_control: per-cycle snapshots of the controls, expected results queued at start.
module tb_fp_add_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sign_1 = 1'b0;
    logic        sign_2 = 1'b0;
    logic [7:0]  saida_registrador = 8'd0;
    logic [7:0]  tamanhoShift = 8'd0;
    logic        directionShift = 1'b0;
    logic        overflow = 1'b0;
    logic [31:0] saida_final = 32'd0;

    logic        soma_multiplica_small_ula, soma_multiplica_big_ula, subtrador_big_ula;
    logic [4:0]  tamanho, tamanho2;
    logic [7:0]  tamanho3;
    logic        decisor_mux_expoente_escolhido, decisor_mux_saida_big_ula;
    logic        decisor_shift_right_left, subtrador_Somador_subtrador;
    logic        load, busy, done;
    logic [31:0] result;

    fp_add_control #(.MAX_RETRY(1)) dut (
        .clk(clk), .reset(reset), .start(start), .sign_1(sign_1), .sign_2(sign_2),
        .saida_registrador(saida_registrador), .tamanhoShift(tamanhoShift),
        .directionShift(directionShift), .overflow(overflow), .saida_final(saida_final),
        .soma_multiplica_small_ula(soma_multiplica_small_ula),
        .soma_multiplica_big_ula(soma_multiplica_big_ula),
        .subtrador_big_ula(subtrador_big_ula), .tamanho(tamanho), .tamanho2(tamanho2),
        .tamanho3(tamanho3), .decisor_mux_expoente_escolhido(decisor_mux_expoente_escolhido),
        .decisor_mux_saida_big_ula(decisor_mux_saida_big_ula),
        .decisor_shift_right_left(decisor_shift_right_left),
        .subtrador_Somador_subtrador(subtrador_Somador_subtrador),
        .load(load), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

`ifdef FP_CTRL_ROUND_RETRY_EN
    localparam int RETRY_DONE_K = 12;
    localparam int RETRY_LOADS  = 4;
`else
    localparam int RETRY_DONE_K = 9;
    localparam int RETRY_LOADS  = 3;
`endif

    typedef struct {
        logic [31:0] res;
        int          k;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    logic [4:0] a_tam[16];
    logic [4:0] a_tam2[16];
    logic [7:0] a_tam3[16];
    logic       a_dsrl[16], a_msbu[16], a_mexp[16], a_sub[16], a_load[16], a_busy[16], a_sbu[16];
    int          c_done_k, c_ndone, c_nld;
    logic [31:0] c_res;
    logic        c_all_busy;

    // Cycle k is the k-th cycle after the edge that accepted start (k=1 is EXP).
    task automatic capture(input int budget, input int pulse_at);
        logic prev_ld;
        prev_ld    = 1'b0;
        c_done_k   = -1;
        c_ndone    = 0;
        c_nld      = 0;
        c_res      = 32'd0;
        c_all_busy = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            start = (k == pulse_at);
            if (k < 16) begin
                a_tam[k]  = tamanho;      a_tam2[k] = tamanho2;   a_tam3[k] = tamanho3;
                a_dsrl[k] = decisor_shift_right_left;
                a_msbu[k] = decisor_mux_saida_big_ula;
                a_mexp[k] = decisor_mux_expoente_escolhido;
                a_sub[k]  = subtrador_Somador_subtrador;
                a_load[k] = load;         a_busy[k] = busy;       a_sbu[k] = subtrador_big_ula;
            end
            if (load && !prev_ld) c_nld++;
            prev_ld = load;
            if (c_done_k < 0 && !busy) c_all_busy = 1'b0;
            if (done) begin
                c_ndone++;
                if (c_done_k < 0) begin
                    c_done_k = k;
                    c_res    = result;
                end
            end
        end
    endtask

    task automatic launch();
        @(negedge clk);
        start = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        @(negedge clk);
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL rst_load got %0b want 0", load); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b want 0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL rst_result got %h want 0", result); end
        checks++;
        if ({soma_multiplica_small_ula, soma_multiplica_big_ula} !== 2'b11) begin
            errors++; $display("FAIL rst_soma got %b want 11", {soma_multiplica_small_ula, soma_multiplica_big_ula});
        end
        checks++; if (tamanho3 !== 8'd0) begin errors++; $display("FAIL rst_tamanho3 got %h want 0", tamanho3); end
        reset = 1'b0;
        saida_final = 32'h3F800000; saida_registrador = 8'd2; tamanhoShift = 8'd3;
        sb.push_back('{res: 32'h3F800000, k: 9});
        launch();
        capture(12, 0);
        if (sb.size() == 0) begin
            checks++; errors++; $display("FAIL rst_sb empty queue got 0 want 1 entry");
        end else begin
            e = sb.pop_front();
            checks++; if (c_done_k !== e.k) begin errors++; $display("FAIL rst_op_done_k got %0d want %0d", c_done_k, e.k); end
            checks++; if (c_res !== e.res) begin errors++; $display("FAIL rst_op_result got %h want %h", c_res, e.res); end
        end
        // Abort a second operation while the exponent load strobe is high.
        launch();
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        checks++; if (load !== 1'b1) begin errors++; $display("FAIL mid_load_pre got %0b want 1", load); end
        reset = 1'b1;
        #1;
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL mid_load got %0b want 0", load); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %0b want 0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL mid_result got %h want 0", result); end
        @(negedge clk);
        reset = 1'b0;
        capture(12, 0);
        checks++; if (c_ndone !== 0) begin errors++; $display("FAIL post_rst_done got %0d want 0", c_ndone); end
        checks++; if (a_busy[5] !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %0b want 0", a_busy[5]); end
    endtask

    task automatic test_add();
        exp_t e;
        sign_1 = 1'b0; sign_2 = 1'b0; saida_registrador = 8'd1; tamanhoShift = 8'd0;
        directionShift = 1'b1; overflow = 1'b0; saida_final = 32'h40490FDB;
        sb.push_back('{res: 32'h40490FDB, k: 9});
        launch();
        capture(14, 0);
        checks++; if (a_sbu[2] !== 1'b0) begin errors++; $display("FAIL add_subbig got %0b want 0", a_sbu[2]); end
        checks++; if (a_tam[2] !== 5'd1) begin errors++; $display("FAIL add_tamanho got %0d want 1", a_tam[2]); end
        checks++; if (a_tam3[2] !== 8'd1) begin errors++; $display("FAIL add_exp_t3 got %h want 01", a_tam3[2]); end
        checks++; if ({a_mexp[2], a_sub[2]} !== 2'b00) begin errors++; $display("FAIL add_exp_sel got %b want 00", {a_mexp[2], a_sub[2]}); end
        checks++; if (a_tam3[4] !== 8'hFF) begin errors++; $display("FAIL add_norm_t3 got %h want ff", a_tam3[4]); end
        checks++; if (a_tam2[4] !== 5'd31) begin errors++; $display("FAIL add_norm_t2 got %0d want 31", a_tam2[4]); end
        checks++; if (a_dsrl[4] !== 1'b1) begin errors++; $display("FAIL add_norm_dir got %0b want 1", a_dsrl[4]); end
        checks++;
        if ({a_mexp[4], a_sub[4], a_msbu[4]} !== 3'b110) begin
            errors++; $display("FAIL add_norm_sel got %b want 110", {a_mexp[4], a_sub[4], a_msbu[4]});
        end
        checks++;
        if ({a_tam3[6], 3'(a_tam2[6]), a_dsrl[6], a_sub[6], a_mexp[6], a_msbu[6]} !== {8'd1, 3'd1, 4'b0010}) begin
            errors++; $display("FAIL add_fin_ctrl got t3=%h t2=%0d d=%0b s=%0b m=%0b b=%0b", a_tam3[6], a_tam2[6], a_dsrl[6], a_sub[6], a_mexp[6], a_msbu[6]);
        end
        checks++;
        if ({a_load[3], a_load[4], a_load[5], a_load[6], a_load[7]} !== 5'b10101) begin
            errors++; $display("FAIL add_load_pattern got %b want 10101", {a_load[3], a_load[4], a_load[5], a_load[6], a_load[7]});
        end
        checks++; if (c_nld !== 3) begin errors++; $display("FAIL add_loads got %0d want 3", c_nld); end
        checks++; if (a_busy[10] !== 1'b0) begin errors++; $display("FAIL add_busy_after got %0b want 0", a_busy[10]); end
        if (sb.size() == 0) begin
            checks++; errors++; $display("FAIL add_sb empty queue got 0 want 1 entry");
        end else begin
            e = sb.pop_front();
            checks++; if (c_done_k !== e.k) begin errors++; $display("FAIL add_done_k got %0d want %0d", c_done_k, e.k); end
            checks++; if (c_res !== e.res) begin errors++; $display("FAIL add_result got %h want %h", c_res, e.res); end
        end
    endtask

    task automatic test_diff_signs();
        exp_t e;
        sign_1 = 1'b1; sign_2 = 1'b0; saida_registrador = 8'd40; tamanhoShift = 8'd5;
        directionShift = 1'b0; saida_final = 32'hBF000000;
        sb.push_back('{res: 32'hBF000000, k: 9});
        launch();
        capture(14, 0);
        checks++; if (a_sbu[2] !== 1'b1) begin errors++; $display("FAIL diff_subbig got %0b want 1", a_sbu[2]); end
        checks++; if (a_tam[2] !== 5'd31) begin errors++; $display("FAIL diff_clamp got %0d want 31", a_tam[2]); end
        checks++; if (a_tam3[2] !== 8'd40) begin errors++; $display("FAIL diff_exp_t3 got %0d want 40", a_tam3[2]); end
        checks++; if (a_tam3[4] !== 8'd5) begin errors++; $display("FAIL diff_norm_t3 got %0d want 5", a_tam3[4]); end
        checks++; if (a_tam2[4] !== 5'd5) begin errors++; $display("FAIL diff_norm_t2 got %0d want 5", a_tam2[4]); end
        checks++; if (a_dsrl[4] !== 1'b0) begin errors++; $display("FAIL diff_norm_dir got %0b want 0", a_dsrl[4]); end
        if (sb.size() == 0) begin
            checks++; errors++; $display("FAIL diff_sb empty queue got 0 want 1 entry");
        end else begin
            e = sb.pop_front();
            checks++; if (c_done_k !== e.k) begin errors++; $display("FAIL diff_done_k got %0d want %0d", c_done_k, e.k); end
            checks++; if (c_res !== e.res) begin errors++; $display("FAIL diff_result got %h want %h", c_res, e.res); end
        end
    endtask

    task automatic test_start_ignored();
        exp_t e;
        saida_final = 32'h12345678;
        sb.push_back('{res: 32'h12345678, k: 9});
        launch();
        capture(14, 4);
        checks++; if (c_ndone !== 1) begin errors++; $display("FAIL ign_ndone got %0d want 1", c_ndone); end
        checks++; if (c_all_busy !== 1'b1) begin errors++; $display("FAIL ign_busy got %0b want 1", c_all_busy); end
        if (sb.size() == 0) begin
            checks++; errors++; $display("FAIL ign_sb empty queue got 0 want 1 entry");
        end else begin
            e = sb.pop_front();
            checks++; if (c_done_k !== e.k) begin errors++; $display("FAIL ign_done_k got %0d want %0d", c_done_k, e.k); end
            checks++; if (c_res !== e.res) begin errors++; $display("FAIL ign_result got %h want %h", c_res, e.res); end
        end
    endtask

    task automatic test_retry();
        exp_t e;
        overflow = 1'b1; saida_final = 32'h7F000000;
        sb.push_back('{res: 32'h7F000000, k: RETRY_DONE_K});
        launch();
        capture(15, 0);
        checks++; if (c_nld !== RETRY_LOADS) begin errors++; $display("FAIL retry_loads got %0d want %0d", c_nld, RETRY_LOADS); end
        checks++; if (a_msbu[6] !== 1'b0) begin errors++; $display("FAIL retry_first_msbu got %0b want 0", a_msbu[6]); end
`ifdef FP_CTRL_ROUND_RETRY_EN
        checks++; if (a_msbu[9] !== 1'b1) begin errors++; $display("FAIL retry_second_msbu got %0b want 1", a_msbu[9]); end
`endif
        if (sb.size() == 0) begin
            checks++; errors++; $display("FAIL retry_sb empty queue got 0 want 1 entry");
        end else begin
            e = sb.pop_front();
            checks++; if (c_done_k !== e.k) begin errors++; $display("FAIL retry_done_k got %0d want %0d", c_done_k, e.k); end
            checks++; if (c_res !== e.res) begin errors++; $display("FAIL retry_result got %h want %h", c_res, e.res); end
        end
        overflow = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n;
        n = 0;
        saida_final = 32'h419AE148;
        sb.push_back('{res: 32'h419AE148, k: 9});
        sb.push_back('{res: 32'hC0000000, k: 19});
        launch();
        for (int k = 1; k <= 30 && n < 2; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++; errors++; $display("FAIL b2b_extra done at k=%0d want none", k);
                end else begin
                    e = sb.pop_front();
                    checks++; if (k !== e.k) begin errors++; $display("FAIL b2b_done_k got %0d want %0d", k, e.k); end
                    checks++; if (result !== e.res) begin errors++; $display("FAIL b2b_result got %h want %h", result, e.res); end
                    n++;
                    saida_final = 32'hC0000000;
                    if (n == 2) start = 1'b0;
                end
            end
        end
        start = 1'b0;
        if (sb.size() != 0) begin
            checks++; errors++; $display("FAIL b2b_timeout got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_diff_signs();
        test_start_ignored();
        test_retry();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
